// File: rtl/regfile.sv
// Register file with a per-register pending-write scoreboard and registered pending count.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile #(
    parameter int W_RD = 5,
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_i,
    input  logic [W_RD-1:0] wbr_num_i,
    input  logic [WORD-1:0] wb_data_i,
    input  logic            issue_i,
    input  logic [W_RD-1:0] issue_rd_i,
    input  logic [W_RD-1:0] rs1_num_i,
    input  logic [W_RD-1:0] rs2_num_i,
    output logic [WORD-1:0] rs1_data_o,
    output logic [WORD-1:0] rs2_data_o,
    output logic            rs1_rdy_o,
    output logic            rs2_rdy_o,
    output logic [W_RD:0]   pend_cnt_o
);
    localparam int NREG = 1 << W_RD;
    localparam logic [W_RD-1:0] REG_ZERO = {W_RD{1'b0}};

    logic [WORD-1:0] mem_r [1:NREG-1];
    logic [NREG-1:1] pend_r;
    logic [NREG-1:1] pend_next_s;
    logic [W_RD:0]   pend_cnt_r;
    logic            wb_en_s;
    logic            issue_en_s;
    logic [W_RD-1:0] rs_num_s [2];

    function automatic logic [W_RD:0] popcount(input logic [NREG-1:1] bits);
        logic [W_RD:0] cnt;
        cnt = {(W_RD+1){1'b0}};
        for (int i = 1; i < NREG; i++) begin
            cnt = cnt + {{W_RD{1'b0}}, bits[i]};
        end
        return cnt;
    endfunction

    assign wb_en_s     = wb_i && (wbr_num_i != REG_ZERO);
    assign issue_en_s  = issue_i && (issue_rd_i != REG_ZERO);
    assign rs_num_s[0] = rs1_num_i;
    assign rs_num_s[1] = rs2_num_i;

    // Scoreboard next state: a same-cycle issue overrides the writeback clear.
    always_comb begin
        pend_next_s = pend_r;
        for (int i = 1; i < NREG; i++) begin
            if (issue_en_s && (issue_rd_i == W_RD'(i))) begin
                pend_next_s[i] = 1'b1;
            end else if (wb_en_s && (wbr_num_i == W_RD'(i))) begin
                pend_next_s[i] = 1'b0;
            end else begin
                pend_next_s[i] = pend_r[i];
            end
        end
    end

    // Scoreboard register and its population count, both reflecting the post-edge state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r     <= {(NREG-1){1'b0}};
            pend_cnt_r <= {(W_RD+1){1'b0}};
        end else begin
            pend_r     <= pend_next_s;
            pend_cnt_r <= popcount(pend_next_s);
        end
    end

    // Data storage; register 0 has no storage so writes to it vanish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                mem_r[i] <= {WORD{1'b0}};
            end
        end else if (wb_en_s) begin
            mem_r[wbr_num_i] <= wb_data_i;
        end
    end

    generate
        for (genvar p = 0; p < 2; p++) begin : g_read
            logic [WORD-1:0] stored_s;
            logic            pend_s;
            logic [WORD-1:0] data_s;
            logic            rdy_s;

            // Stored value and pending bit of the addressed register; x0 is hardwired.
            always_comb begin
                if (rs_num_s[p] == REG_ZERO) begin
                    stored_s = {WORD{1'b0}};
                    pend_s   = 1'b0;
                end else begin
                    stored_s = mem_r[rs_num_s[p]];
                    pend_s   = pend_r[rs_num_s[p]];
                end
            end

`ifdef REGFILE_BYPASS_EN
            logic hit_s;
            assign hit_s = wb_en_s && (wbr_num_i == rs_num_s[p]);

            // Forward writeback data; a same-cycle re-reservation keeps the operand not ready.
            always_comb begin
                if (!rst) begin
                    data_s = {WORD{1'b0}};
                    rdy_s  = 1'b1;
                end else if (hit_s) begin
                    data_s = wb_data_i;
                    rdy_s  = !(issue_en_s && (issue_rd_i == rs_num_s[p]));
                end else begin
                    data_s = stored_s;
                    rdy_s  = !pend_s;
                end
            end
`else
            // Plain read: old value during a same-cycle write.
            always_comb begin
                if (!rst) begin
                    data_s = {WORD{1'b0}};
                    rdy_s  = 1'b1;
                end else begin
                    data_s = stored_s;
                    rdy_s  = !pend_s;
                end
            end
`endif
        end
    endgenerate

    assign rs1_data_o = g_read[0].data_s;
    assign rs2_data_o = g_read[1].data_s;
    assign rs1_rdy_o  = g_read[0].rdy_s;
    assign rs2_rdy_o  = g_read[1].rdy_s;
    assign pend_cnt_o = pend_cnt_r;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array/scoreboard reference model.
module tb_regfile;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_i;
    logic [4:0]  wbr_num_i;
    logic [31:0] wb_data_i;
    logic        issue_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  rs1_num_i;
    logic [4:0]  rs2_num_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        rs1_rdy_o;
    logic        rs2_rdy_o;
    logic [5:0]  pend_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_reg [32];
    bit          m_pend [32];

    regfile dut (
        .clk(clk), .rst(rst), .wb_i(wb_i), .wbr_num_i(wbr_num_i), .wb_data_i(wb_data_i),
        .issue_i(issue_i), .issue_rd_i(issue_rd_i), .rs1_num_i(rs1_num_i), .rs2_num_i(rs2_num_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .rs1_rdy_o(rs1_rdy_o),
        .rs2_rdy_o(rs2_rdy_o), .pend_cnt_o(pend_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_data(input logic [4:0] n);
        if (!rst || n == 5'd0) return 32'd0;
        if (BYPASS && wb_i && wbr_num_i != 5'd0 && wbr_num_i == n) return wb_data_i;
        return m_reg[n];
    endfunction

    function automatic logic exp_rdy(input logic [4:0] n);
        if (!rst || n == 5'd0) return 1'b1;
        if (BYPASS && wb_i && wbr_num_i != 5'd0 && wbr_num_i == n)
            return !(issue_i && issue_rd_i == n);
        return !m_pend[n];
    endfunction

    function automatic logic [5:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return 6'(c);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic idle();
        wb_i    = 1'b0;
        issue_i = 1'b0;
    endtask

    // Advance one edge; model applies clear-then-set so a same-cycle issue wins.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (wb_i && wbr_num_i != 5'd0) begin
                m_reg[wbr_num_i]  = wb_data_i;
                m_pend[wbr_num_i] = 1'b0;
            end
            if (issue_i && issue_rd_i != 5'd0) m_pend[issue_rd_i] = 1'b1;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle(); model_clear();
        wbr_num_i = 5'd0; wb_data_i = 32'd0; issue_rd_i = 5'd0;
        rs1_num_i = 5'd3; rs2_num_i = 5'd17;
        #2;
        vectors++;
        if (rs1_data_o !== 32'd0) begin miscompares++; $display("FAIL reset_rs1_data: got %h expected %h", rs1_data_o, 32'd0); end
        vectors++;
        if (rs2_rdy_o !== 1'b1) begin miscompares++; $display("FAIL reset_rs2_rdy: got %b expected 1", rs2_rdy_o); end
        vectors++;
        if (pend_cnt_o !== 6'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", pend_cnt_o); end
        apply_reset();
    endtask

    task automatic test_x0();
        rs1_num_i = 5'd0; wb_i = 1'b1; wbr_num_i = 5'd0; wb_data_i = 32'hDEADBEEF;
        #2;
        vectors++;
        if (rs1_data_o !== 32'd0 || rs1_rdy_o !== 1'b1) begin miscompares++; $display("FAIL x0_before: got %h/%b expected 0/1", rs1_data_o, rs1_rdy_o); end
        tick(); idle(); #1;
        vectors++;
        if (rs1_data_o !== 32'd0 || rs1_rdy_o !== 1'b1) begin miscompares++; $display("FAIL x0_after: got %h/%b expected 0/1", rs1_data_o, rs1_rdy_o); end
        vectors++;
        if (pend_cnt_o !== 6'd0) begin miscompares++; $display("FAIL x0_cnt: got %0d expected 0", pend_cnt_o); end
    endtask

    task automatic test_issue_wb();
        logic [31:0] ed;
        apply_reset();
        rs2_num_i = 5'd5; issue_i = 1'b1; issue_rd_i = 5'd5;
        tick(); idle();
        vectors++;
        if (pend_cnt_o !== 6'd1) begin miscompares++; $display("FAIL iw_cnt1: got %0d expected 1", pend_cnt_o); end
        for (int c = 1; c <= 2; c++) begin
            #2;
            vectors++;
            if (rs2_rdy_o !== 1'b0) begin miscompares++; $display("FAIL iw_rdy_c%0d: got %b expected 0", c, rs2_rdy_o); end
            tick();
        end
        wb_i = 1'b1; wbr_num_i = 5'd5; wb_data_i = 32'h1234;
        #2;
        ed = BYPASS ? 32'h1234 : 32'd0;
        vectors++;
        if (rs2_rdy_o !== BYPASS) begin miscompares++; $display("FAIL iw_rdy_c3: got %b expected %b", rs2_rdy_o, BYPASS); end
        vectors++;
        if (rs2_data_o !== ed) begin miscompares++; $display("FAIL iw_data_c3: got %h expected %h", rs2_data_o, ed); end
        tick(); idle();
        vectors++;
        if (pend_cnt_o !== 6'd0) begin miscompares++; $display("FAIL iw_cnt0: got %0d expected 0", pend_cnt_o); end
        #2;
        vectors++;
        if (rs2_data_o !== 32'h1234 || rs2_rdy_o !== 1'b1) begin miscompares++; $display("FAIL iw_c4: got %h/%b expected 1234/1", rs2_data_o, rs2_rdy_o); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] ed;
        apply_reset();
        rs1_num_i = 5'd7; issue_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        wb_i = 1'b1; wbr_num_i = 5'd7; wb_data_i = 32'hA5A5A5A5;
        #2;
        ed = BYPASS ? 32'hA5A5A5A5 : 32'd0;
        vectors++;
        if (rs1_rdy_o !== 1'b0) begin miscompares++; $display("FAIL sc_rdy_pre: got %b expected 0", rs1_rdy_o); end
        vectors++;
        if (rs1_data_o !== ed) begin miscompares++; $display("FAIL sc_data_pre: got %h expected %h", rs1_data_o, ed); end
        tick(); idle();
        vectors++;
        if (pend_cnt_o !== 6'd1) begin miscompares++; $display("FAIL sc_cnt: got %0d expected 1", pend_cnt_o); end
        #2;
        vectors++;
        if (rs1_data_o !== 32'hA5A5A5A5 || rs1_rdy_o !== 1'b0) begin miscompares++; $display("FAIL sc_post: got %h/%b expected a5a5a5a5/0", rs1_data_o, rs1_rdy_o); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int r = 1; r < 32; r++) begin
            issue_i = 1'b1; issue_rd_i = 5'(r);
            tick();
            vectors++;
            if (pend_cnt_o !== 6'(r)) begin miscompares++; $display("FAIL fill_cnt r%0d: got %0d expected %0d", r, pend_cnt_o, r); end
        end
        idle();
        for (int r = 1; r < 32; r++) begin
            wb_i = 1'b1; wbr_num_i = 5'(r); wb_data_i = 32'(r * 3);
            tick();
            vectors++;
            if (pend_cnt_o !== 6'(31 - r)) begin miscompares++; $display("FAIL drain_cnt r%0d: got %0d expected %0d", r, pend_cnt_o, 31 - r); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        wb_i = 1'b1; wbr_num_i = 5'd3; wb_data_i = 32'h33; issue_i = 1'b1; issue_rd_i = 5'd2;
        tick(); wb_i = 1'b0; issue_rd_i = 5'd4;
        tick(); issue_rd_i = 5'd6;
        tick(); idle();
        vectors++;
        if (pend_cnt_o !== 6'd3) begin miscompares++; $display("FAIL ar_cnt3: got %0d expected 3", pend_cnt_o); end
        rs1_num_i = 5'd3; rs2_num_i = 5'd2;
        #2;
        vectors++;
        if (rs1_data_o !== 32'h33 || rs2_rdy_o !== 1'b0) begin miscompares++; $display("FAIL ar_pre: got %h/%b expected 33/0", rs1_data_o, rs2_rdy_o); end
        #1 rst = 1'b0; model_clear();
        #1;
        vectors++;
        if (rs1_data_o !== 32'd0 || rs2_rdy_o !== 1'b1 || pend_cnt_o !== 6'd0) begin miscompares++; $display("FAIL ar_async: got %h/%b/%0d expected 0/1/0", rs1_data_o, rs2_rdy_o, pend_cnt_o); end
        wb_i = 1'b1; wbr_num_i = 5'd3; wb_data_i = 32'hFFFF0000;
        #1;
        vectors++;
        if (rs1_data_o !== 32'd0 || rs1_rdy_o !== 1'b1) begin miscompares++; $display("FAIL ar_held: got %h/%b expected 0/1", rs1_data_o, rs1_rdy_o); end
        @(posedge clk);
        #3 rst = 1'b1; idle();
        #1;
        vectors++;
        if (rs1_data_o !== 32'd0 || rs2_rdy_o !== 1'b1 || pend_cnt_o !== 6'd0) begin miscompares++; $display("FAIL ar_release: got %h/%b/%0d expected 0/1/0", rs1_data_o, rs2_rdy_o, pend_cnt_o); end
    endtask

    task automatic test_bypass();
        logic [31:0] ed;
        apply_reset();
        wb_i = 1'b1; wbr_num_i = 5'd9; wb_data_i = 32'h11;
        tick();
        rs1_num_i = 5'd9; rs2_num_i = 5'd9; wb_data_i = 32'h55;
        #2;
        ed = BYPASS ? 32'h55 : 32'h11;
        vectors++;
        if (rs1_data_o !== ed || rs2_data_o !== ed) begin miscompares++; $display("FAIL byp_same: got %h/%h expected %h", rs1_data_o, rs2_data_o, ed); end
        tick(); idle();
        #2;
        vectors++;
        if (rs1_data_o !== 32'h55 || rs2_data_o !== 32'h55) begin miscompares++; $display("FAIL byp_next: got %h/%h expected 55", rs1_data_o, rs2_data_o); end
    endtask

    task automatic test_random();
        logic [31:0] d1, d2;
        logic        r1, r2;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            wb_i       = 1'($urandom_range(0, 1));
            wbr_num_i  = 5'($urandom_range(0, 31));
            wb_data_i  = $urandom;
            issue_i    = 1'($urandom_range(0, 1));
            issue_rd_i = ($urandom_range(0, 3) == 0) ? wbr_num_i : 5'($urandom_range(0, 31));
            rs1_num_i  = ($urandom_range(0, 3) == 0) ? wbr_num_i : 5'($urandom_range(0, 31));
            rs2_num_i  = ($urandom_range(0, 3) == 0) ? issue_rd_i : 5'($urandom_range(0, 31));
            #2;
            d1 = exp_data(rs1_num_i); d2 = exp_data(rs2_num_i);
            r1 = exp_rdy(rs1_num_i);  r2 = exp_rdy(rs2_num_i);
            vectors++;
            if (rs1_data_o !== d1 || rs1_rdy_o !== r1) begin miscompares++; $display("FAIL rnd_rs1 n%0d: got %h/%b expected %h/%b", n, rs1_data_o, rs1_rdy_o, d1, r1); end
            vectors++;
            if (rs2_data_o !== d2 || rs2_rdy_o !== r2) begin miscompares++; $display("FAIL rnd_rs2 n%0d: got %h/%b expected %h/%b", n, rs2_data_o, rs2_rdy_o, d2, r2); end
            tick();
            vectors++;
            if (pend_cnt_o !== exp_cnt()) begin miscompares++; $display("FAIL rnd_cnt n%0d: got %0d expected %0d", n, pend_cnt_o, exp_cnt()); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_x0();
        test_issue_wb();
        test_same_cycle();
        test_fill();
        test_async_reset();
        test_bypass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
